// File: rtl/matrix_row_scanner_pkg.sv
// matrix_pkg: shared types and constants for the 7x5 LED matrix row scanner.
//   state_t        scanner FSM states (idle / blanking gap / row lit)
//   MATRIX_ROWS    physical row count of the matrix
//   MATRIX_COLS    physical column count of the matrix
//   HH_MODE_*      encodings of the 2-bit display mode HH
package matrix_pkg;

   // Enum literals carry an ST_ prefix so they never collide with the
   // BLANK timing parameter of the scanner.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   localparam int unsigned MATRIX_ROWS = 7;
   localparam int unsigned MATRIX_COLS = 5;

   localparam logic [1:0] HH_MODE_0 = 2'b00;
   localparam logic [1:0] HH_MODE_1 = 2'b01;
   localparam logic [1:0] HH_MODE_2 = 2'b10;
   localparam logic [1:0] HH_MODE_3 = 2'b11;

endpackage

// File: rtl/matrix_row_scanner_if.sv
// matrix_row_scanner_if: signal bundle between the row scanner and its
// environment (mode selector, preset stages, LED matrix drivers).
//   en          scan enable
//   hh_in       requested display mode
//   col_data    column patterns, row r at [r*COLS +: COLS]
//   hh_out      frame-stable mode broadcast to the preset stages
//   row_n       active-low one-hot row drive
//   col         active-high column drive
//   row_idx     index of the row currently being scanned
//   frame_start one-cycle pulse at the first cycle of row 0's slot
// master: environment side; slave: scanner side.
interface matrix_row_scanner_if
   import matrix_pkg::*;
#(
   parameter int ROWS = MATRIX_ROWS,
   parameter int COLS = MATRIX_COLS
);
   localparam int IW = $clog2(ROWS);

   logic                 en;
   logic [1:0]           hh_in;
   logic [ROWS*COLS-1:0] col_data;
   logic [1:0]           hh_out;
   logic [ROWS-1:0]      row_n;
   logic [COLS-1:0]      col;
   logic [IW-1:0]        row_idx;
   logic                 frame_start;

   modport master (
      output en, hh_in, col_data,
      input  hh_out, row_n, col, row_idx, frame_start
   );

   modport slave (
      input  en, hh_in, col_data,
      output hh_out, row_n, col, row_idx, frame_start
   );

endinterface

// File: rtl/matrix_row_scanner_row_slot_timer.sv
// row_slot_timer: cycle counter for one scanner state (blank or show phase).
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clr          restart counting from 0 on the next edge
//   o_blank_last   counter is on the last cycle of a BLANK-cycle phase
//   o_show_last    counter is on the last cycle of a (DIV-BLANK)-cycle phase
module row_slot_timer #(
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_blank_last,
   output logic o_show_last
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else            r_cnt <= r_cnt + CW'(1);
   end

   assign o_blank_last = (r_cnt == CW'(BLANK - 1));
   assign o_show_last  = (r_cnt == CW'(DIV - BLANK - 1));

endmodule

// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner: time-multiplexed row driver for the LED matrix.
// Latches the display mode once per frame, then scans rows one at a time,
// each slot being BLANK dark cycles followed by DIV-BLANK lit cycles.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         matrix_row_scanner_if.slave (en, hh_in, col_data in;
//               hh_out, row_n, col, row_idx, frame_start out)
module matrix_row_scanner
   import matrix_pkg::*;
#(
   parameter int ROWS  = MATRIX_ROWS,
   parameter int COLS  = MATRIX_COLS,
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   matrix_row_scanner_if.slave bus
);

   localparam int IW = $clog2(ROWS);
   localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);

   state_t          r_state, w_state_nxt;
   logic [IW-1:0]   r_row_idx, w_row_idx_nxt;
   logic [1:0]      r_hh, w_hh_nxt;
   logic [ROWS-1:0] r_row_n, w_row_n_nxt;
   logic [COLS-1:0] r_col, w_col_nxt;
   logic            r_fs, w_fs_nxt;
   logic            w_clr, w_blank_last, w_show_last;

   row_slot_timer #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clr        (w_clr),
      .o_blank_last (w_blank_last),
      .o_show_last  (w_show_last)
   );

   // Counter restarts on every state entry and is parked at 0 while idle.
   assign w_clr = (w_state_nxt != r_state) || (r_state == ST_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; dropping en overrides everything, including a
   // frame boundary on the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.en) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE:  w_state_nxt = ST_BLANK;
            ST_BLANK: if (w_blank_last) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_show_last)  w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output logic: next values of the registered outputs, decoded from the
   // transition being taken so row_n/col change exactly on state entry.
   always_comb begin
      w_row_n_nxt   = '1;
      w_col_nxt     = '0;
      w_fs_nxt      = 1'b0;
      w_hh_nxt      = r_hh;
      w_row_idx_nxt = r_row_idx;
      unique case (w_state_nxt)
         ST_IDLE: begin
            w_row_idx_nxt = '0;
         end
         ST_BLANK: begin
            if (r_state == ST_IDLE) begin
               w_row_idx_nxt = '0;
               w_hh_nxt      = bus.hh_in;
               w_fs_nxt      = 1'b1;
            end else if (r_state == ST_SHOW) begin
               if (r_row_idx == LAST_ROW) begin
                  w_row_idx_nxt = '0;
                  w_hh_nxt      = bus.hh_in;
                  w_fs_nxt      = 1'b1;
               end else begin
                  w_row_idx_nxt = r_row_idx + IW'(1);
               end
            end
         end
         ST_SHOW: begin
            w_row_n_nxt[r_row_idx] = 1'b0;
            // Slice is captured on the last blank cycle, then held.
            w_col_nxt = (r_state == ST_BLANK) ? bus.col_data[r_row_idx*COLS +: COLS] : r_col;
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_n   <= '1;
         r_col     <= '0;
         r_hh      <= '0;
         r_row_idx <= '0;
         r_fs      <= 1'b0;
      end else begin
         r_row_n   <= w_row_n_nxt;
         r_col     <= w_col_nxt;
         r_hh      <= w_hh_nxt;
         r_row_idx <= w_row_idx_nxt;
         r_fs      <= w_fs_nxt;
      end
   end

   assign bus.row_n       = r_row_n;
   assign bus.col         = r_col;
   assign bus.hh_out      = r_hh;
   assign bus.row_idx     = r_row_idx;
   assign bus.frame_start = r_fs;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// tb_matrix_row_scanner: bench for matrix_row_scanner with DIV=8, BLANK=2.
// Reference model tracks the scan as a single time offset within the frame
// (row = t / DIV, position in slot = t % DIV) rather than as an FSM.
module tb_matrix_row_scanner;

   localparam int ROWS  = 7;
   localparam int COLS  = 5;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = ROWS * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_row_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   matrix_row_scanner #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .DIV   (DIV),
      .BLANK (BLANK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model state
   bit              m_active = 1'b0;
   int              m_t      = 0;
   logic [1:0]      m_hh     = '0;
   logic [COLS-1:0] m_col    = '0;

   typedef struct {
      logic            en;
      logic [ROWS-1:0] row_n;
      logic [COLS-1:0] col;
      logic [2:0]      idx;
      logic            fs;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int m_row();
      return m_active ? (m_t / DIV) : 0;
   endfunction

   function automatic int m_pos();
      return m_t % DIV;
   endfunction

   // Advance model and DUT by one clock; sample #1 after the edge.
   task automatic tick();
      if (!rst_n) begin
         m_active = 1'b0; m_t = 0; m_hh = '0; m_col = '0;
      end else if (!bus.en) begin
         m_active = 1'b0; m_t = 0;
      end else begin
         if (!m_active) begin
            m_active = 1'b1; m_t = 0; m_hh = bus.hh_in;
         end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) m_hh = bus.hh_in;
         end
         if (m_pos() == BLANK) m_col = bus.col_data[m_row()*COLS +: COLS];
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_model(input string tag);
      logic [ROWS-1:0] e_row_n;
      logic [COLS-1:0] e_col;
      bit              lit;
      lit     = m_active && (m_pos() >= BLANK);
      e_row_n = '1;
      if (lit) e_row_n[m_row()] = 1'b0;
      e_col = lit ? m_col : '0;
      chk({tag, ".row_n"},   bus.row_n,       e_row_n);
      chk({tag, ".col"},     bus.col,         e_col);
      chk({tag, ".row_idx"}, bus.row_idx,     m_row());
      chk({tag, ".fs"},      bus.frame_start, (m_active && m_t == 0));
      chk({tag, ".hh_out"},  bus.hh_out,      m_hh);
   endtask

   initial begin
      int  last_fs;
      int  n_fs;
      bit  got;

      bus.en       = 1'b0;
      bus.hh_in    = 2'b01;
      bus.col_data = 35'({$urandom, $urandom});
      bus.col_data[0*COLS +: COLS] = 5'b10011;
      bus.col_data[1*COLS +: COLS] = 5'b00110;
      bus.col_data[2*COLS +: COLS] = 5'b10101;
      bus.col_data[3*COLS +: COLS] = 5'b01010;

      tbl[0]  = '{1'b1, 7'h7F, 5'h00, 3'd0, 1'b1};
      tbl[1]  = '{1'b1, 7'h7F, 5'h00, 3'd0, 1'b0};
      for (int i = 2; i < 8; i++) tbl[i] = '{1'b1, 7'h7E, 5'h13, 3'd0, 1'b0};
      tbl[8]  = '{1'b1, 7'h7F, 5'h00, 3'd1, 1'b0};
      tbl[9]  = '{1'b1, 7'h7F, 5'h00, 3'd1, 1'b0};
      tbl[10] = '{1'b1, 7'h7D, 5'h06, 3'd1, 1'b0};
      tbl[11] = '{1'b0, 7'h7F, 5'h00, 3'd0, 1'b0};

      // reset state
      repeat (2) tick();
      chk("rst.row_n",   bus.row_n,       7'h7F);
      chk("rst.col",     bus.col,         5'h00);
      chk("rst.hh_out",  bus.hh_out,      2'b00);
      chk("rst.row_idx", bus.row_idx,     3'd0);
      chk("rst.fs",      bus.frame_start, 1'b0);
      rst_n = 1'b1;
      tick();
      check_model("idle");

      // first frame start, table driven
      for (int i = 0; i < 12; i++) begin
         bus.en = tbl[i].en;
         tick();
         chk("tbl.row_n",   bus.row_n,       tbl[i].row_n);
         chk("tbl.col",     bus.col,         tbl[i].col);
         chk("tbl.row_idx", bus.row_idx,     tbl[i].idx);
         chk("tbl.fs",      bus.frame_start, tbl[i].fs);
         if (tbl[i].en) chk("tbl.hh_out", bus.hh_out, 2'b01);
      end

      // free run for 3 frames
      bus.en  = 1'b1;
      last_fs = -1;
      n_fs    = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         tick();
         check_model("run");
         chk("run.one_row", ($countones(~bus.row_n) <= 1), 1'b1);
         if (bus.frame_start === 1'b1) begin
            n_fs++;
            if (last_fs >= 0) chk("run.fs_period", cyc - last_fs, FRAME);
            last_fs = cyc;
         end
         if (m_row() == 2 && m_pos() >= BLANK) begin
            chk("run.row2_col", bus.col,   5'b10101);
            chk("run.row2_n",   bus.row_n, 7'b1111011);
         end
         if (m_row() == 3 && m_pos() < BLANK)  chk("run.gap_col",  bus.col, 5'b00000);
         if (m_row() == 3 && m_pos() >= BLANK) chk("run.row3_col", bus.col, 5'b01010);
      end
      chk("run.fs_count", n_fs, 3);

      // mode change mid-frame takes effect at next frame boundary
      for (int k = 0; k < FRAME && !(m_row() == 3 && m_pos() == 4); k++) begin
         tick();
         check_model("adv3");
      end
      bus.hh_in = 2'b10;
      got = 1'b0;
      for (int k = 0; k < FRAME && !got; k++) begin
         tick();
         check_model("hh");
         if (m_active && m_t == 0) begin
            chk("hh.boundary", bus.hh_out,      2'b10);
            chk("hh.fs",       bus.frame_start, 1'b1);
            got = 1'b1;
         end else begin
            chk("hh.hold", bus.hh_out, 2'b01);
         end
      end
      chk("hh.boundary_seen", got, 1'b1);

      // drop en during show of row 4
      for (int k = 0; k < FRAME && !(m_row() == 4 && m_pos() == 5); k++) begin
         tick();
         check_model("adv4");
      end
      bus.en = 1'b0;
      tick();
      chk("en_drop.row_n",   bus.row_n,   7'h7F);
      chk("en_drop.col",     bus.col,     5'h00);
      chk("en_drop.row_idx", bus.row_idx, 3'd0);
      chk("en_drop.hh_out",  bus.hh_out,  2'b10);
      check_model("en_drop");
      tick();
      check_model("idle2");
      bus.en = 1'b1;
      tick();
      chk("en_rise.fs",  bus.frame_start, 1'b1);
      chk("en_rise.idx", bus.row_idx,     3'd0);
      check_model("en_rise");

      // asynchronous reset between edges, mid-show
      for (int k = 0; k < FRAME && !(m_row() == 2 && m_pos() == 4); k++) begin
         tick();
         check_model("adv2");
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.row_n",   bus.row_n,       7'h7F);
      chk("arst.hh_out",  bus.hh_out,      2'b00);
      chk("arst.col",     bus.col,         5'h00);
      chk("arst.row_idx", bus.row_idx,     3'd0);
      chk("arst.fs",      bus.frame_start, 1'b0);
      repeat (3) begin
         tick();
         check_model("arst_hold");
      end
      rst_n = 1'b1;
      tick();
      chk("arst_rel.fs", bus.frame_start, 1'b1);
      check_model("arst_rel");

      // randomized run
      for (int k = 0; k < 800; k++) begin
         if (bus.en) begin
            if ($urandom_range(0, 39) == 0) bus.en = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            bus.en = 1'b1;
         end
         if ($urandom_range(0, 15) == 0) bus.hh_in = 2'($urandom);
         if ($urandom_range(0, 7) == 0)  bus.col_data = 35'({$urandom, $urandom});
         tick();
         check_model("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
